osc_pattern_gen: RTL and testbench
==================================

Name: osc_pattern_gen

Overview:
- Parametrised successor to the single-pattern oscillator LED test.
- Derives a slow tick from the board oscillator (24 MHz default) using a prescaler.
- Debounces a push-button; each clean press cycles through four LED pattern modes.
- Drives an N-wide LED bank and exports the tick and current mode for bring-up and scope checks. Sits directly under the board top level.

Parameters:
- OscF, 24000000, clock frequency in Hz; benches use small values for short sims.
- TickHz, 4, pattern update rate in Hz. TickDiv = OscF/TickHz (integer division); TickDiv must be >= 2.
- NumLeds, 3, LED bank width; must be >= 2.
- DebounceCycles, OscF/100, consecutive stable samples required to accept a button level change; must be >= 1.

Ports:
- clk  input  1  oscillator clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset. Assertion clears all state immediately; release is synchronous to clk.
- button  input  1  raw asynchronous push-button, active-high.
- led  output  NumLeds  LED pattern, registered.
- mode  output  2  current mode, registered.
- tick  output  1  one-cycle pulse at each pattern update, registered.

Behaviour:
- Reset values: led=0, mode=0, tick=0, prescaler=0, synchronisers=0, debounce level=0, debounce counter=0, press=0.
- Synchroniser: two flops, s1 then s2. button is never used unsynchronised.
- Debounce:
  - Counter clears whenever s2 equals the debounced level.
  - While s2 differs from the debounced level, the counter increments each cycle.
  - When the counter is at DebounceCycles-1 and s2 still differs, the debounced level flips and the counter clears.
  - press is a registered one-cycle pulse on the debounced 0->1 edge.
  - Latency: the mode register changes exactly DebounceCycles+3 edges after the first edge that samples button=1, provided button holds.
- Glitches shorter than DebounceCycles produce no press.
- A held button yields exactly one press. A new press requires a debounced release of DebounceCycles low samples.
- Prescaler:
  - Counts 0..TickDiv-1 and wraps.
  - tick=1 for the single cycle after the count reaches TickDiv-1, giving period TickDiv.
  - press forces the prescaler to 0, so the first tick after a press comes TickDiv cycles later.
- Modes and tick action (tick seen in cycle N; led changes at end of N, visible at N+1):
  - 0 COUNT: led = led+1 modulo 2^NumLeds; all-ones wraps to 0.
  - 1 WALK: one-hot rotate left; MSB wraps to bit 0.
  - 2 BLINK: led = ~led.
  - 3 HOLD: led unchanged; tick still pulses.
- press: mode <= mode+1 modulo 4, so 3 wraps to 0. led is re-initialised in the same edge:
  - entering COUNT: 0
  - entering WALK: 1
  - entering BLINK: 0
  - entering HOLD: keeps its current value
- Simultaneous press and tick: press wins. led takes the press init value and the tick update is dropped; the tick output still pulses that cycle.
- WALK never shows 0 or more than one bit set.
- rst_n asserted mid-operation (including mid-debounce or mid-tick) returns all state to reset values asynchronously. After release, operation restarts in COUNT from 0, with the first tick TickDiv cycles after release.

Test Plan:
- Bench setting for all cases: OscF=40, TickHz=4 (TickDiv=10), NumLeds=3, DebounceCycles=4.
- Reset, then run 100 cycles with no button -> mode=0; tick pulses every 10 cycles; led steps 1,2,...,7,0,1,2; tick width 1 cycle.
- Clean press held 20 cycles -> mode changes to 1 exactly 7 edges after the first high sample; led=1 at that edge; then led 2,4,1 on the following ticks; no second mode change while held.
- Bounce: 2-cycle high pulses separated by 2-cycle lows, repeated 5 times, then low -> mode stays 0 and led continues counting.
- Four clean presses with release -> mode sequence 1,2,3,0. In BLINK, led=0 at entry then 7,0,7. In HOLD, led is frozen while tick keeps pulsing. Back in COUNT, led restarts from 0.
- Press timed so the press pulse coincides with a tick -> led equals the init value of the new mode, not the ticked value; next tick is 10 cycles later.
- Assert rst_n low for 3 cycles mid-debounce in WALK with led=4 -> led, mode and tick go to 0 immediately without waiting for a clock edge. After release there is no spurious press; first tick after 10 cycles gives led=1.

Source files
------------

// File: rtl/osc_pattern_gen.sv
// Oscillator-driven LED pattern generator: prescaled update tick, debounced
// mode button, and four LED pattern modes on an N-wide bank.

module osc_pg_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  // Two-flop synchroniser for the raw button level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

module osc_pg_debounce #(
  parameter int Cycles = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_press
);

  localparam int CntW = (Cycles > 1) ? $clog2(Cycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Cycles - 1);
  localparam logic [CntW-1:0] CntZero = {CntW{1'b0}};
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [CntW-1:0] r_cnt;
  logic            r_level;
  logic            r_level_d;
  logic            r_press;

  // Accept a new level only after Cycles consecutive differing samples;
  // the press pulse is one cycle after the debounced rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= CntZero;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      if (i_level == r_level) begin
        r_cnt <= CntZero;
      end else if (r_cnt == CntLast) begin
        r_level <= i_level;
        r_cnt   <= CntZero;
      end else begin
        r_cnt <= r_cnt + CntOne;
      end
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign o_press = r_press;

endmodule

module osc_pg_prescaler #(
  parameter int Div = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CntW = $clog2(Div);
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);
  localparam logic [CntW-1:0] CntZero = {CntW{1'b0}};
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [CntW-1:0] r_cnt;
  logic            r_tick;

  // A restart realigns the count so the next tick is a full period away
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= CntZero;
      r_tick <= 1'b0;
    end else if (i_restart) begin
      r_cnt  <= CntZero;
      r_tick <= 1'b0;
    end else if (r_cnt == CntLast) begin
      r_cnt  <= CntZero;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CntOne;
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

module osc_pg_pattern #(
  parameter int Width = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_press,
  input  logic             i_tick,
  output logic [Width-1:0] o_led,
  output logic [1:0]       o_mode
);

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  localparam logic [Width-1:0] LedZero = {Width{1'b0}};
  localparam logic [Width-1:0] LedOne  = {{(Width-1){1'b0}}, 1'b1};

  mode_e            r_mode;
  logic [Width-1:0] r_led;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_COUNT: next_mode = MODE_WALK;
      MODE_WALK:  next_mode = MODE_BLINK;
      MODE_BLINK: next_mode = MODE_HOLD;
      MODE_HOLD:  next_mode = MODE_COUNT;
      default:    next_mode = MODE_COUNT;
    endcase
  endfunction

  // HOLD freezes whatever the bank showed when the mode was entered
  function automatic logic [Width-1:0] entry_led(input mode_e m, input logic [Width-1:0] cur);
    case (m)
      MODE_COUNT: entry_led = LedZero;
      MODE_WALK:  entry_led = LedOne;
      MODE_BLINK: entry_led = LedZero;
      MODE_HOLD:  entry_led = cur;
      default:    entry_led = LedZero;
    endcase
  endfunction

  function automatic logic [Width-1:0] tick_led(input mode_e m, input logic [Width-1:0] cur);
    case (m)
      MODE_COUNT: tick_led = cur + LedOne;
      MODE_WALK:  tick_led = {cur[Width-2:0], cur[Width-1]};
      MODE_BLINK: tick_led = ~cur;
      MODE_HOLD:  tick_led = cur;
      default:    tick_led = cur;
    endcase
  endfunction

  // Mode FSM; a press takes priority over a coincident tick update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_COUNT;
      r_led  <= LedZero;
    end else if (i_press) begin
      r_mode <= next_mode(r_mode);
      r_led  <= entry_led(next_mode(r_mode), r_led);
    end else if (i_tick) begin
      r_led <= tick_led(r_mode, r_led);
    end
  end

  assign o_led  = r_led;
  assign o_mode = r_mode;

endmodule

module osc_pattern_gen #(
  parameter int OscF           = 24000000,
  parameter int TickHz         = 4,
  parameter int NumLeds        = 3,
  parameter int DebounceCycles = OscF / 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               button,
  output logic [NumLeds-1:0] led,
  output logic [1:0]         mode,
  output logic               tick
);

  localparam int TickDiv = OscF / TickHz;

  logic w_btn_sync;
  logic w_press;
  logic w_tick;

  osc_pg_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (button),
    .o_q   (w_btn_sync)
  );

  osc_pg_debounce #(.Cycles(DebounceCycles)) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (w_btn_sync),
    .o_press (w_press)
  );

  osc_pg_prescaler #(.Div(TickDiv)) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_press),
    .o_tick    (w_tick)
  );

  osc_pg_pattern #(.Width(NumLeds)) u_pattern (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_press (w_press),
    .i_tick  (w_tick),
    .o_led   (led),
    .o_mode  (mode)
  );

  assign tick = w_tick;

endmodule

// File: tb/tb_osc_pattern_gen.sv
// Directed bench for osc_pattern_gen: TickDiv=10, DebounceCycles=4, 3 LEDs.

module tb_osc_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic       button;
  logic [2:0] led;
  logic [1:0] mode;
  logic       tick;

  int n_pass        = 0;
  int n_total       = 0;
  int cyc           = 0;
  int last_tick_cyc = 0;

  osc_pattern_gen #(
    .OscF           (40),
    .TickHz         (4),
    .NumLeds        (3),
    .DebounceCycles (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .button (button),
    .led    (led),
    .mode   (mode),
    .tick   (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_led(input string tag, input logic [7:0] exp);
    chk(tag, {5'd0, led}, exp);
  endtask

  task automatic chk_mode(input string tag, input logic [7:0] exp);
    chk(tag, {6'd0, mode}, exp);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (tick === 1'b1) last_tick_cyc = cyc;
    end
  endtask

  // Waits (bounded) for the next tick and checks its distance from the reference
  task automatic wait_tick(input string tag);
    int start;
    int n;
    start = last_tick_cyc;
    n = 0;
    do begin
      step(1);
      n++;
    end while (tick !== 1'b1 && n < 30);
    chk({tag, "_seen"}, {7'd0, tick}, 8'd1);
    chk({tag, "_gap"}, 8'(cyc - start), 8'd10);
  endtask

  initial begin
    button = 1'b0;
    rst_n  = 1'b0;
    step(2);
    chk_led("rst_led", 8'd0);
    chk_mode("rst_mode", 8'd0);
    chk("rst_tick", {7'd0, tick}, 8'd0);
    rst_n = 1'b1;
    last_tick_cyc = cyc;

    // Free-running COUNT
    for (int i = 1; i <= 10; i++) begin
      wait_tick("t1");
      chk_mode("t1_mode", 8'd0);
      step(1);
      chk("t1_width", {7'd0, tick}, 8'd0);
      chk_led("t1_led", 8'(i % 8));
    end

    // Bounce shorter than the debounce window
    for (int k = 0; k < 5; k++) begin
      button = 1'b1;
      step(2);
      button = 1'b0;
      step(2);
      chk_mode("bounce_mode", 8'd0);
    end
    chk_led("bounce_led", 8'd4);
    wait_tick("bounce");
    step(1);
    chk_led("bounce_led2", 8'd5);

    // Clean press held 20 cycles
    button = 1'b1;
    step(7);
    chk_mode("t2_mode_e6", 8'd0);
    chk_led("t2_led_e6", 8'd5);
    step(1);
    chk_mode("t2_mode_e7", 8'd1);
    chk_led("t2_led_e7", 8'd1);
    last_tick_cyc = cyc;
    wait_tick("t2_a");
    step(1);
    chk_led("t2_led_a", 8'd2);
    step(1);
    button = 1'b0;
    wait_tick("t2_b");
    step(1);
    chk_led("t2_led_b", 8'd4);
    chk_mode("t2_mode_held", 8'd1);

    // Async reset mid-debounce in WALK
    button = 1'b1;
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_led("arst_led", 8'd0);
    chk_mode("arst_mode", 8'd0);
    chk("arst_tick", {7'd0, tick}, 8'd0);
    button = 1'b0;
    step(3);
    rst_n = 1'b1;
    last_tick_cyc = cyc;
    wait_tick("arst");
    step(1);
    chk_led("arst_led_after", 8'd1);
    chk_mode("arst_mode_after", 8'd0);

    // Press 1: COUNT -> WALK
    wait_tick("p1_pre");
    button = 1'b1;
    step(7);
    chk_mode("p1_mode_e6", 8'd0);
    chk_led("p1_led_e6", 8'd2);
    step(1);
    chk_mode("p1_mode", 8'd1);
    chk_led("p1_led", 8'd1);
    button = 1'b0;
    last_tick_cyc = cyc;

    // Press 2: WALK -> BLINK
    wait_tick("p2_pre");
    button = 1'b1;
    step(7);
    chk_mode("p2_mode_e6", 8'd1);
    chk_led("p2_led_e6", 8'd2);
    step(1);
    chk_mode("p2_mode", 8'd2);
    chk_led("p2_led", 8'd0);
    button = 1'b0;
    last_tick_cyc = cyc;
    wait_tick("blink_a");
    step(1);
    chk_led("blink_led_a", 8'd7);
    wait_tick("blink_b");
    step(1);
    chk_led("blink_led_b", 8'd0);
    wait_tick("blink_c");
    step(1);
    chk_led("blink_led_c", 8'd7);

    // Press 3: BLINK -> HOLD keeps current value
    button = 1'b1;
    step(7);
    chk_mode("p3_mode_e6", 8'd2);
    step(1);
    chk_mode("p3_mode", 8'd3);
    chk_led("p3_led", 8'd7);
    button = 1'b0;
    last_tick_cyc = cyc;
    wait_tick("hold_a");
    step(1);
    chk_led("hold_led_a", 8'd7);
    wait_tick("hold_b");
    step(1);
    chk_led("hold_led_b", 8'd7);
    chk_mode("hold_mode", 8'd3);

    // Press 4: HOLD -> COUNT restarts at 0
    button = 1'b1;
    step(7);
    chk_mode("p4_mode_e6", 8'd3);
    step(1);
    chk_mode("p4_mode", 8'd0);
    chk_led("p4_led", 8'd0);
    button = 1'b0;
    last_tick_cyc = cyc;
    wait_tick("p4");
    step(1);
    chk_led("p4_led_tick", 8'd1);

    // Press pulse coinciding with a tick
    step(2);
    button = 1'b1;
    step(7);
    chk("t5_tick", {7'd0, tick}, 8'd1);
    chk_mode("t5_mode_pre", 8'd0);
    chk_led("t5_led_pre", 8'd1);
    step(1);
    chk_mode("t5_mode", 8'd1);
    chk_led("t5_led", 8'd1);
    chk("t5_tick_low", {7'd0, tick}, 8'd0);
    button = 1'b0;
    last_tick_cyc = cyc;
    wait_tick("t5_next");
    step(1);
    chk_led("t5_led_next", 8'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
